// File: rtl/z80_bus_arbiter.sv
// rtl/z80_bus_arbiter.sv - Z80 bus arbiter: host accesses via BUSRQ/BUSAK with CPU passthrough
module z80_bus_arbiter #(
  parameter int WAIT_STATES   = 1,
  parameter int BUSAK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        host_req,
  input  logic        host_we,
  input  logic        host_io,
  input  logic [15:0] host_addr,
  input  logic [7:0]  host_wdata,
  output logic [7:0]  host_rdata,
  output logic        host_ack,
  output logic        host_err,
  output logic        busrq_n,
  input  logic        busak_n,
  input  logic [15:0] cpu_A,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_mreq_n,
  input  logic        cpu_iorq_n,
  input  logic        cpu_rd_n,
  input  logic        cpu_wr_n,
  output logic [15:0] bus_A,
  output logic [7:0]  bus_dout,
  output logic        bus_mreq_n,
  output logic        bus_iorq_n,
  output logic        bus_rd_n,
  output logic        bus_wr_n,
  output logic        bus_data_oe,
  input  logic [7:0]  bus_di
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_GRANT, S_T1, S_T2, S_T3, S_ACK, S_RELEASE
  } state_t;

  localparam logic [7:0] WS  = 8'(WAIT_STATES);
  localparam logic [7:0] TMO = 8'(BUSAK_TIMEOUT);

  state_t      state_q, state_d;
  logic [7:0]  tmo_cnt_q, tmo_cnt_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        we_q, we_d;
  logic        io_q, io_d;
  logic        busrq_n_q, busrq_n_d;
  logic        host_ack_q, host_ack_d;
  logic        host_err_q, host_err_d;
  logic [7:0]  host_rdata_q, host_rdata_d;
  logic [15:0] reg_a_q, reg_a_d;
  logic [7:0]  reg_dout_q, reg_dout_d;
  logic        reg_mreq_n_q, reg_mreq_n_d;
  logic        reg_iorq_n_q, reg_iorq_n_d;
  logic        reg_rd_n_q, reg_rd_n_d;
  logic        reg_wr_n_q, reg_wr_n_d;
  logic        reg_oe_q, reg_oe_d;
  logic        passthru;

  // Next-state, counters, host-side latches and completion pulses
  always_comb begin
    state_d      = state_q;
    tmo_cnt_d    = tmo_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    we_d         = we_q;
    io_d         = io_q;
    host_rdata_d = host_rdata_q;
    host_ack_d   = 1'b0;
    host_err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (host_req) begin
          state_d   = S_REQ;
          tmo_cnt_d = 8'd0;
        end
      end
      S_REQ: begin
        if (!busak_n) begin
          state_d = S_GRANT;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
          if (tmo_cnt_q + 8'd1 == TMO) begin
            // Grant never came: complete the request with an error flag
            state_d    = S_IDLE;
            host_err_d = 1'b1;
            host_ack_d = 1'b1;
          end
        end
      end
      S_GRANT: begin
        if (host_req) begin
          state_d = S_T1;
          addr_d  = host_addr;
          wdata_d = host_wdata;
          we_d    = host_we;
          io_d    = host_io;
        end else begin
          state_d = S_RELEASE;
        end
      end
      S_T1: begin
        state_d    = S_T2;
        wait_cnt_d = WS;
      end
      S_T2: begin
        if (wait_cnt_q != 8'd0) begin
          wait_cnt_d = wait_cnt_q - 8'd1;
        end else begin
          state_d = S_T3;
        end
      end
      S_T3: begin
        if (!we_q) begin
          host_rdata_d = bus_di;
        end
        host_ack_d = 1'b1;
        state_d    = S_ACK;
      end
      S_ACK:     state_d = S_GRANT;
      S_RELEASE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Registered bus drive values, decoded from the state being entered
  always_comb begin
    busrq_n_d    = !(state_d inside {S_REQ, S_GRANT, S_T1, S_T2, S_T3, S_ACK});
    reg_a_d      = addr_d;
    reg_dout_d   = wdata_d;
    reg_mreq_n_d = 1'b1;
    reg_iorq_n_d = 1'b1;
    reg_rd_n_d   = 1'b1;
    reg_wr_n_d   = 1'b1;
    reg_oe_d     = 1'b0;
    case (state_d)
      S_T1: begin
        reg_mreq_n_d = io_d;
        reg_iorq_n_d = !io_d;
        reg_oe_d     = we_d;
      end
      S_T2, S_T3: begin
        reg_mreq_n_d = io_d;
        reg_iorq_n_d = !io_d;
        reg_rd_n_d   = we_d;
        reg_wr_n_d   = !we_d;
        reg_oe_d     = we_d;
      end
      default: ;
    endcase
  end

  // State and output registers; reset drops straight back to CPU passthrough
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      tmo_cnt_q    <= 8'd0;
      wait_cnt_q   <= 8'd0;
      addr_q       <= 16'd0;
      wdata_q      <= 8'd0;
      we_q         <= 1'b0;
      io_q         <= 1'b0;
      busrq_n_q    <= 1'b1;
      host_ack_q   <= 1'b0;
      host_err_q   <= 1'b0;
      host_rdata_q <= 8'd0;
      reg_a_q      <= 16'd0;
      reg_dout_q   <= 8'd0;
      reg_mreq_n_q <= 1'b1;
      reg_iorq_n_q <= 1'b1;
      reg_rd_n_q   <= 1'b1;
      reg_wr_n_q   <= 1'b1;
      reg_oe_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      tmo_cnt_q    <= tmo_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      io_q         <= io_d;
      busrq_n_q    <= busrq_n_d;
      host_ack_q   <= host_ack_d;
      host_err_q   <= host_err_d;
      host_rdata_q <= host_rdata_d;
      reg_a_q      <= reg_a_d;
      reg_dout_q   <= reg_dout_d;
      reg_mreq_n_q <= reg_mreq_n_d;
      reg_iorq_n_q <= reg_iorq_n_d;
      reg_rd_n_q   <= reg_rd_n_d;
      reg_wr_n_q   <= reg_wr_n_d;
      reg_oe_q     <= reg_oe_d;
    end
  end

  // CPU owns the pads until the grant is in hand
  assign passthru = (state_q == S_IDLE) || (state_q == S_REQ);

  assign bus_A       = passthru ? cpu_A      : reg_a_q;
  assign bus_dout    = passthru ? cpu_dout   : reg_dout_q;
  assign bus_mreq_n  = passthru ? cpu_mreq_n : reg_mreq_n_q;
  assign bus_iorq_n  = passthru ? cpu_iorq_n : reg_iorq_n_q;
  assign bus_rd_n    = passthru ? cpu_rd_n   : reg_rd_n_q;
  assign bus_wr_n    = passthru ? cpu_wr_n   : reg_wr_n_q;
  assign bus_data_oe = passthru ? !cpu_wr_n  : reg_oe_q;

  assign busrq_n    = busrq_n_q;
  assign host_ack   = host_ack_q;
  assign host_err   = host_err_q;
  assign host_rdata = host_rdata_q;

endmodule

// File: tb/tb_z80_bus_arbiter.sv
// tb/tb_z80_bus_arbiter.sv - directed self-checking bench for z80_bus_arbiter
module tb_z80_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        host_req = 1'b0, host_we = 1'b0, host_io = 1'b0;
  logic [15:0] host_addr = 16'd0;
  logic [7:0]  host_wdata = 8'd0;
  logic [7:0]  host_rdata;
  logic        host_ack, host_err, busrq_n;
  logic        busak_n = 1'b1;
  logic [15:0] cpu_A = 16'd0;
  logic [7:0]  cpu_dout = 8'd0;
  logic        cpu_mreq_n = 1'b1, cpu_iorq_n = 1'b1, cpu_rd_n = 1'b1, cpu_wr_n = 1'b1;
  logic [15:0] bus_A;
  logic [7:0]  bus_dout;
  logic        bus_mreq_n, bus_iorq_n, bus_rd_n, bus_wr_n, bus_data_oe;
  logic [7:0]  bus_di = 8'd0;

  int n_checks = 0;
  int n_errors = 0;

  z80_bus_arbiter #(.WAIT_STATES(1), .BUSAK_TIMEOUT(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .host_req(host_req), .host_we(host_we), .host_io(host_io),
    .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rdata(host_rdata), .host_ack(host_ack), .host_err(host_err),
    .busrq_n(busrq_n), .busak_n(busak_n),
    .cpu_A(cpu_A), .cpu_dout(cpu_dout), .cpu_mreq_n(cpu_mreq_n),
    .cpu_iorq_n(cpu_iorq_n), .cpu_rd_n(cpu_rd_n), .cpu_wr_n(cpu_wr_n),
    .bus_A(bus_A), .bus_dout(bus_dout), .bus_mreq_n(bus_mreq_n),
    .bus_iorq_n(bus_iorq_n), .bus_rd_n(bus_rd_n), .bus_wr_n(bus_wr_n),
    .bus_data_oe(bus_data_oe), .bus_di(bus_di)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic check_bus(input string tag, input logic mreq, input logic iorq,
                           input logic rd, input logic wr, input logic oe);
    check_val({tag, "_mreq"}, 32'(bus_mreq_n), 32'(mreq));
    check_val({tag, "_iorq"}, 32'(bus_iorq_n), 32'(iorq));
    check_val({tag, "_rd"},   32'(bus_rd_n),   32'(rd));
    check_val({tag, "_wr"},   32'(bus_wr_n),   32'(wr));
    check_val({tag, "_oe"},   32'(bus_data_oe), 32'(oe));
  endtask

  // From IDLE: raise the request, answer busak one cycle after busrq_n drops; ends in GRANT
  task automatic do_request(input logic we, input logic io, input logic [15:0] addr,
                            input logic [7:0] wd);
    host_we = we; host_io = io; host_addr = addr; host_wdata = wd; host_req = 1'b1;
    cyc();
    check_val("req_busrq", 32'(busrq_n), 32'd0);
    check_val("req_passthru_a", 32'(bus_A), 32'(cpu_A));
    busak_n = 1'b0;
    cyc();
    check_val("grant_busrq", 32'(busrq_n), 32'd0);
    check_bus("grant", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
  endtask

  // From GRANT with host_req high: T1, T2, T2, T3, ACK; ends in ACK
  task automatic do_access(input logic we, input logic io, input logic [15:0] addr,
                           input logic [7:0] wd, input logic [7:0] exp_rdata);
    logic ms, is;
    ms = io; is = !io;
    cyc();
    busak_n = 1'b1;
    check_val("t1_addr", 32'(bus_A), 32'(addr));
    check_bus("t1", ms, is, 1'b1, 1'b1, we);
    if (we) check_val("t1_dout", 32'(bus_dout), 32'(wd));
    for (int i = 0; i < 2; i++) begin
      cyc();
      check_bus("t2", ms, is, we, !we, we);
      check_val("t2_ack", 32'(host_ack), 32'd0);
      check_val("t2_busrq", 32'(busrq_n), 32'd0);
    end
    cyc();
    check_bus("t3", ms, is, we, !we, we);
    cyc();
    check_val("ack", 32'(host_ack), 32'd1);
    check_val("ack_err", 32'(host_err), 32'd0);
    check_val("ack_rdata", 32'(host_rdata), 32'(exp_rdata));
    check_val("ack_busrq", 32'(busrq_n), 32'd0);
    check_bus("ack", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
  endtask

  // From ACK with host_req low: GRANT, RELEASE, IDLE
  task automatic do_release();
    cyc();
    check_val("post_ack", 32'(host_ack), 32'd0);
    check_val("post_ack_busrq", 32'(busrq_n), 32'd0);
    cyc();
    check_val("rel_busrq", 32'(busrq_n), 32'd1);
    check_val("rel_regs_a", 32'(bus_A), 32'(host_addr));
    cyc();
    check_val("idle_passthru_a", 32'(bus_A), 32'(cpu_A));
    check_val("idle_busrq", 32'(busrq_n), 32'd1);
  endtask

  initial begin
    #13;
    check_val("rst_busrq", 32'(busrq_n), 32'd1);
    check_val("rst_ack", 32'(host_ack), 32'd0);
    check_val("rst_err", 32'(host_err), 32'd0);
    check_val("rst_rdata", 32'(host_rdata), 32'd0);
    reset_n = 1'b1;
    cyc();

    // Passthrough
    cpu_A = 16'h1234; cpu_mreq_n = 1'b0;
    #1;
    check_val("pt_a", 32'(bus_A), 32'h1234);
    check_val("pt_mreq", 32'(bus_mreq_n), 32'd0);
    check_val("pt_oe_rd", 32'(bus_data_oe), 32'd0);
    check_val("pt_busrq", 32'(busrq_n), 32'd1);
    cpu_wr_n = 1'b0; cpu_dout = 8'h55;
    #1;
    check_val("pt_oe_wr", 32'(bus_data_oe), 32'd1);
    check_val("pt_dout", 32'(bus_dout), 32'h55);
    cpu_wr_n = 1'b1; cpu_mreq_n = 1'b1;
    cyc();

    // Memory read
    bus_di = 8'hA5;
    do_request(1'b0, 1'b0, 16'h8000, 8'h00);
    do_access(1'b0, 1'b0, 16'h8000, 8'h00, 8'hA5);
    host_req = 1'b0;
    do_release();

    // I/O write; read data register must stay untouched
    bus_di = 8'hEE;
    do_request(1'b1, 1'b1, 16'h00FE, 8'h3C);
    do_access(1'b1, 1'b1, 16'h00FE, 8'h3C, 8'hA5);
    host_req = 1'b0;
    do_release();

    // Back-to-back reads reuse the grant
    bus_di = 8'h11;
    do_request(1'b0, 1'b0, 16'h4000, 8'h00);
    do_access(1'b0, 1'b0, 16'h4000, 8'h00, 8'h11);
    host_addr = 16'h4001; bus_di = 8'h22;
    cyc();
    check_val("b2b_grant_busrq", 32'(busrq_n), 32'd0);
    do_access(1'b0, 1'b0, 16'h4001, 8'h00, 8'h22);
    host_req = 1'b0;
    do_release();

    // Grant timeout after 4 cycles in REQ
    busak_n = 1'b1;
    host_we = 1'b0; host_io = 1'b0; host_addr = 16'h2000; host_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check_val("tmo_wait_busrq", 32'(busrq_n), 32'd0);
      check_val("tmo_wait_ack", 32'(host_ack), 32'd0);
    end
    cyc();
    check_val("tmo_err", 32'(host_err), 32'd1);
    check_val("tmo_ack", 32'(host_ack), 32'd1);
    check_val("tmo_busrq", 32'(busrq_n), 32'd1);
    check_val("tmo_passthru", 32'(bus_A), 32'(cpu_A));
    host_req = 1'b0;
    cyc();
    check_val("tmo_err_clr", 32'(host_err), 32'd0);
    check_val("tmo_ack_clr", 32'(host_ack), 32'd0);
    check_val("tmo_idle_busrq", 32'(busrq_n), 32'd1);

    // Reset in the middle of a write's T2
    do_request(1'b1, 1'b0, 16'h9000, 8'h77);
    cyc();
    busak_n = 1'b1;
    cyc();
    check_val("pre_rst_wr", 32'(bus_wr_n), 32'd0);
    #1;
    reset_n = 1'b0;
    #1;
    check_val("rst_wr_pt", 32'(bus_wr_n), 32'(cpu_wr_n));
    check_val("rst_oe_pt", 32'(bus_data_oe), 32'd0);
    check_val("rst_mid_busrq", 32'(busrq_n), 32'd1);
    host_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check_val("rst_no_ack", 32'(host_ack), 32'd0);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check_val("post_rst_ack", 32'(host_ack), 32'd0);
      check_val("post_rst_busrq", 32'(busrq_n), 32'd1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/z80_bus_arbiter.md
Z80_BUS_ARBITER -- requirements
Module: z80_bus_arbiter

Interface
REQ-001 Parameter WAIT_STATES, default 1, SHALL set extra T2 cycles per host access (0..255).
REQ-002 Parameter BUSAK_TIMEOUT, default 255, SHALL set max cycles waiting for bus grant (1..255).
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 reset_n  in  1  reset, asynchronous, active-low.
REQ-005 host_req  in  1  host access request; held high until host_ack.
REQ-006 host_we / host_io  in  1 each  write when 1 / I/O space (iorq_n) when 1, else memory (mreq_n).
REQ-007 host_addr  in  16, host_wdata  in  8  access address / write data.
REQ-008 host_rdata  out  8, host_ack  out  1, host_err  out  1  read data, completion pulse, grant-timeout pulse.
REQ-009 busrq_n  out  1, busak_n  in  1  Z80 bus request / acknowledge.
REQ-010 cpu_A  in  16, cpu_dout  in  8, cpu_mreq_n / cpu_iorq_n / cpu_rd_n / cpu_wr_n  in  1 each  CPU bus outputs.
REQ-011 bus_A  out  16, bus_dout  out  8, bus_mreq_n / bus_iorq_n / bus_rd_n / bus_wr_n  out  1 each, bus_data_oe  out  1 (1 = drive data pins), bus_di  in  8  pad-side bus.

Function
REQ-012 States SHALL be IDLE, REQ, GRANT, T1, T2, T3, ACK, RELEASE; all outputs registered except the bus mux.
REQ-013 In IDLE and REQ, bus_* SHALL equal cpu_* combinationally and bus_data_oe SHALL equal ~cpu_wr_n.
REQ-014 In GRANT..RELEASE, bus_* SHALL come from arbiter registers; strobes high except as given below; bus_data_oe low except in T1..T3 of a write.
REQ-015 IDLE: host_req=1 -> REQ, busrq_n driven low from the next cycle, timeout counter cleared.
REQ-016 REQ: busak_n sampled low -> GRANT; else counter increments; counter reaching BUSAK_TIMEOUT -> IDLE with host_err=1 and host_ack=1 for one cycle, busrq_n high.
REQ-017 GRANT: host_req=1 -> T1, latching host_addr, host_wdata, host_we, host_io; host_req=0 -> RELEASE.
REQ-018 T1: bus_A = latched address; bus_mreq_n=0 (or bus_iorq_n=0 if host_io); bus_dout = latched data for writes.
REQ-019 T2: strobe held; bus_rd_n=0 (read) or bus_wr_n=0 (write); wait counter loaded with WAIT_STATES on entry; stays in T2 while counter nonzero, decrementing each cycle.
REQ-020 T3: strobes held; on exit edge host_rdata SHALL capture bus_di for reads (unchanged for writes); -> ACK.
REQ-021 ACK: all strobes high; host_ack=1 for exactly this cycle; host_req ignored; -> GRANT.
REQ-022 RELEASE: strobes high, busrq_n driven high; -> IDLE next cycle.
REQ-023 Back-to-back requests SHALL reuse the grant without dropping busrq_n (GRANT -> T1 directly).
REQ-024 Host access length GRANT-to-ack SHALL be 4+WAIT_STATES cycles (T1, T2 x(1+WAIT_STATES), T3, ACK).
REQ-025 busak_n SHALL be sampled only in REQ; its deassertion in later states is ignored.
REQ-026 host_ack and host_err SHALL never be high in the same cycle except on timeout.

Reset
REQ-027 reset_n low SHALL immediately force IDLE, busrq_n=1, host_ack=0, host_err=0, host_rdata=0, counters=0, bus_* back to CPU passthrough, regardless of current state.
REQ-028 After reset release, first transition SHALL occur on a rising edge with reset_n high.

Verification
REQ-029 Passthrough: no host_req, cpu_A=16'h1234, cpu_mreq_n=0 -> bus_A=16'h1234, bus_mreq_n=0 same cycle, busrq_n=1.
REQ-030 Memory read, WAIT_STATES=1: host_addr=16'h8000, busak_n low one cycle after busrq_n, bus_di=8'hA5 -> bus_mreq_n/bus_rd_n low, ack 5 cycles after GRANT, host_rdata=8'hA5, bus returned after RELEASE.
REQ-031 I/O write: host_io=1, host_we=1, addr 16'h00FE, data 8'h3C -> bus_iorq_n=0, bus_wr_n=0 in T2, bus_data_oe=1 T1..T3, bus_mreq_n stays 1.
REQ-032 Back-to-back: two reads, host_req reasserted after first ack -> busrq_n low throughout, second T1 directly after GRANT.
REQ-033 Timeout: BUSAK_TIMEOUT=4, busak_n held high -> host_err and host_ack pulse together, busrq_n returns high, state IDLE.
REQ-034 Reset mid-T2 of write -> bus_wr_n follows cpu_wr_n immediately, busrq_n=1, no host_ack issued.
